// File: rtl/ay8_mem_responder_pkg.sv
// rtl/ay8_mem_responder_pkg.sv - ay8_mem_pkg: bus cycle encodings, FSM state type and default widths
package ay8_mem_pkg;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_DRIVE = 2'd1,
    ST_WR_DATA  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/ay8_mem_responder_if.sv
// rtl/ay8_mem_responder_if.sv - AY8 multiplexed address/data bus as seen by core (master) and memory (slave)
interface ay8_mem_responder_if
  import ay8_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic              bus_req;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;

  modport master (
    output bus_req,
    output bus_rw,
    output bus_in,
    input  bus_out,
    input  bus_oe
  );

  modport slave (
    input  bus_req,
    input  bus_rw,
    input  bus_in,
    output bus_out,
    output bus_oe
  );

endinterface

// File: rtl/ay8_mem_array.sv
// rtl/ay8_mem_array.sv - DEPTH x DATA_W storage, two sync write ports (bus over loader), one async read port
module ay8_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Bus write is issued last so it overrides a loader write to the same word.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
    if (bus_we)  mem[bus_addr]  <= bus_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ay8_mem_responder.sv
// rtl/ay8_mem_responder.sv - AY8 memory-side bus responder; AY8_MEM_ROM_PROTECT_EN blocks bus writes below ROM_TOP
module ay8_mem_responder
  import ay8_mem_pkg::*;
#(
  parameter int              ADDR_W  = ADDR_W_DEFAULT,
  parameter int              DATA_W  = DATA_W_DEFAULT,
  parameter logic [ADDR_W-1:0] ROM_TOP = ADDR_W'('h80)
) (
  input  logic              CLK,
  input  logic              RST,
  ay8_mem_responder_if.slave bus,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              proto_err,
  output logic [15:0]       rd_count
);

  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] RD_DRIVE = ST_RD_DRIVE;
  localparam logic [1:0] WR_DATA  = ST_WR_DATA;

`ifdef AY8_MEM_ROM_PROTECT_EN
  localparam bit ROM_PROTECT = 1'b1;
`else
  localparam bit ROM_PROTECT = 1'b0;
`endif

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_q;
  logic              oe_q;
  logic              wr_blocked;
  logic              bus_we;

  assign wr_blocked = ROM_PROTECT && (addr < ROM_TOP);
  // Gating with RST makes a reset during WR_DATA abandon the commit.
  assign bus_we     = RST && (state == WR_DATA) && !wr_blocked;

  ay8_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (CLK),
    .bus_we    (bus_we),
    .bus_addr  (addr),
    .bus_data  (bus.bus_in),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_addr   (bus.bus_in[ADDR_W-1:0]),
    .rd_data   (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      addr      <= '0;
      out_q     <= '0;
      oe_q      <= 1'b0;
      proto_err <= 1'b0;
      rd_count  <= 16'h0000;
    end else begin
      proto_err <= 1'b0;
      oe_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.bus_req) begin
            addr <= bus.bus_in[ADDR_W-1:0];
            if (bus.bus_rw == MEM_READ) begin
              out_q <= rd_data;
              oe_q  <= 1'b1;
              state <= RD_DRIVE;
            end else if (bus.bus_rw == MEM_WRITE) begin
              state <= WR_DATA;
            end
          end
        end
        RD_DRIVE: begin
          rd_count <= rd_count + 16'd1;
          state    <= IDLE;
          if (bus.bus_req) proto_err <= 1'b1;
        end
        WR_DATA: begin
          state <= IDLE;
          if (bus.bus_req || wr_blocked) proto_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bus_out = out_q;
  assign bus.bus_oe  = oe_q;

endmodule

// File: tb/tb_ay8_mem_responder.sv
// tb/tb_ay8_mem_responder.sv - directed self-checking bench for ay8_mem_responder
module tb_ay8_mem_responder;
  import ay8_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_we = 1'b0;
  logic [7:0]  load_addr = 8'h00;
  logic [7:0]  load_data = 8'h00;
  logic        proto_err;
  logic [15:0] rd_count;

  int n_tests = 0;
  int n_fail  = 0;

  ay8_mem_responder_if #(.DATA_W(8)) bif ();

  ay8_mem_responder dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bif.slave),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .proto_err (proto_err),
    .rd_count  (rd_count)
  );

  always #5 clk = ~clk;

  // All tasks start and end just after a negedge.
  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic oe1, output logic [7:0] d1,
                          output logic oe2, output logic [15:0] cnt);
    bif.bus_req = 1'b1; bif.bus_rw = MEM_READ; bif.bus_in = a;
    @(negedge clk);
    oe1 = bif.bus_oe; d1 = bif.bus_out;
    bif.bus_req = 1'b0;
    @(negedge clk);
    oe2 = bif.bus_oe; cnt = rd_count;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d, output logic perr);
    bif.bus_req = 1'b1; bif.bus_rw = MEM_WRITE; bif.bus_in = a;
    @(negedge clk);
    bif.bus_req = 1'b0; bif.bus_in = d;
    @(negedge clk);
    perr = proto_err;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (bif.bus_oe !== 1'b0) begin $display("FAIL reset_oe got %b want 0", bif.bus_oe); n_fail++; end
    n_tests++; if (bif.bus_out !== 8'h00) begin $display("FAIL reset_out got %h want 00", bif.bus_out); n_fail++; end
    n_tests++; if (proto_err !== 1'b0) begin $display("FAIL reset_perr got %b want 0", proto_err); n_fail++; end
    n_tests++; if (rd_count !== 16'h0000) begin $display("FAIL reset_cnt got %h want 0000", rd_count); n_fail++; end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_read();
    logic oe1, oe2; logic [7:0] d; logic [15:0] c;
    do_load(8'h00, 8'h0A);
    n_tests++; if (bif.bus_oe !== 1'b0) begin $display("FAIL idle_oe got %b want 0", bif.bus_oe); n_fail++; end
    bus_read(8'h00, oe1, d, oe2, c);
    n_tests++; if (oe1 !== 1'b1) begin $display("FAIL lr_oe got %b want 1", oe1); n_fail++; end
    n_tests++; if (d !== 8'h0A) begin $display("FAIL lr_data got %h want 0a", d); n_fail++; end
    n_tests++; if (oe2 !== 1'b0) begin $display("FAIL lr_oe_drop got %b want 0", oe2); n_fail++; end
    n_tests++; if (c !== 16'd1) begin $display("FAIL lr_cnt got %h want 0001", c); n_fail++; end
    n_tests++; if (bif.bus_out !== 8'h0A) begin $display("FAIL lr_hold got %h want 0a", bif.bus_out); n_fail++; end
  endtask

  task automatic test_write_read();
    logic perr, oe1, oe2; logic [7:0] d; logic [15:0] c;
    bus_write(8'h90, 8'h5C, perr);
    n_tests++; if (perr !== 1'b0) begin $display("FAIL wr_perr got %b want 0", perr); n_fail++; end
    bus_read(8'h90, oe1, d, oe2, c);
    n_tests++; if (d !== 8'h5C) begin $display("FAIL wr_rd_data got %h want 5c", d); n_fail++; end
    n_tests++; if (c !== 16'd2) begin $display("FAIL wr_rd_cnt got %h want 0002", c); n_fail++; end
  endtask

  task automatic test_collision();
    logic perr, oe1, oe2; logic [7:0] d; logic [15:0] c;
    bif.bus_req = 1'b1; bif.bus_rw = MEM_WRITE; bif.bus_in = 8'h95;
    @(negedge clk);
    bif.bus_req = 1'b0; bif.bus_in = 8'h22;
    load_we = 1'b1; load_addr = 8'h95; load_data = 8'h11;
    @(negedge clk);
    load_we = 1'b0;
    bus_read(8'h95, oe1, d, oe2, c);
    n_tests++; if (d !== 8'h22) begin $display("FAIL coll_bus_wins got %h want 22", d); n_fail++; end
    do_load(8'h96, 8'h44);
    load_we = 1'b1; load_addr = 8'h96; load_data = 8'h77;
    bus_read(8'h96, oe1, d, oe2, c);
    load_we = 1'b0;
    n_tests++; if (d !== 8'h44) begin $display("FAIL coll_rd_old got %h want 44", d); n_fail++; end
    bus_read(8'h96, oe1, d, oe2, c);
    n_tests++; if (d !== 8'h77) begin $display("FAIL coll_rd_new got %h want 77", d); n_fail++; end
    n_tests++; if (c !== 16'd5) begin $display("FAIL coll_cnt got %h want 0005", c); n_fail++; end
  endtask

  task automatic test_proto_err();
    logic perr, oe1, oe2; logic [7:0] d; logic [15:0] c;
    bif.bus_req = 1'b1; bif.bus_rw = MEM_READ; bif.bus_in = 8'h00;
    @(negedge clk);
    n_tests++; if (bif.bus_oe !== 1'b1) begin $display("FAIL pe_oe got %b want 1", bif.bus_oe); n_fail++; end
    n_tests++; if (bif.bus_out !== 8'h0A) begin $display("FAIL pe_data got %h want 0a", bif.bus_out); n_fail++; end
    bif.bus_in = 8'h90;
    @(negedge clk);
    bif.bus_req = 1'b0;
    n_tests++; if (proto_err !== 1'b1) begin $display("FAIL pe_pulse got %b want 1", proto_err); n_fail++; end
    n_tests++; if (bif.bus_oe !== 1'b0) begin $display("FAIL pe_ignored_oe got %b want 0", bif.bus_oe); n_fail++; end
    @(negedge clk);
    n_tests++; if (proto_err !== 1'b0) begin $display("FAIL pe_one_cycle got %b want 0", proto_err); n_fail++; end
    n_tests++; if (bif.bus_oe !== 1'b0) begin $display("FAIL pe_no_drive got %b want 0", bif.bus_oe); n_fail++; end
    n_tests++; if (rd_count !== 16'd6) begin $display("FAIL pe_cnt got %h want 0006", rd_count); n_fail++; end
    // Back-to-back: write then read with no idle cycle between them.
    bus_write(8'h97, 8'hC3, perr);
    bus_read(8'h97, oe1, d, oe2, c);
    n_tests++; if (d !== 8'hC3 || perr !== 1'b0) begin $display("FAIL b2b got %h/%b want c3/0", d, perr); n_fail++; end
  endtask

  task automatic test_reset_mid_write();
    logic oe1, oe2; logic [7:0] d; logic [15:0] c;
    do_load(8'h90, 8'hA7);
    bif.bus_req = 1'b1; bif.bus_rw = MEM_WRITE; bif.bus_in = 8'h90;
    @(negedge clk);
    bif.bus_req = 1'b0; bif.bus_in = 8'hFF; rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bif.bus_oe !== 1'b0) begin $display("FAIL rmw_oe got %b want 0", bif.bus_oe); n_fail++; end
    n_tests++; if (proto_err !== 1'b0) begin $display("FAIL rmw_perr got %b want 0", proto_err); n_fail++; end
    n_tests++; if (rd_count !== 16'h0000) begin $display("FAIL rmw_cnt got %h want 0000", rd_count); n_fail++; end
    rst = 1'b1;
    @(negedge clk);
    bus_read(8'h90, oe1, d, oe2, c);
    n_tests++; if (d !== 8'hA7) begin $display("FAIL rmw_mem got %h want a7", d); n_fail++; end
  endtask

  task automatic test_wrap();
    logic oe1, oe2; logic [7:0] d; logic [15:0] c;
    force dut.rd_count = 16'hFFFE;
    #1 release dut.rd_count;
    bus_read(8'h00, oe1, d, oe2, c);
    n_tests++; if (c !== 16'hFFFF) begin $display("FAIL wrap_ffff got %h want ffff", c); n_fail++; end
    bus_read(8'h00, oe1, d, oe2, c);
    n_tests++; if (c !== 16'h0000) begin $display("FAIL wrap_zero got %h want 0000", c); n_fail++; end
  endtask

  task automatic test_rom_protect();
    logic perr, oe1, oe2; logic [7:0] d; logic [15:0] c;
    do_load(8'h10, 8'hEE);
    bus_write(8'h10, 8'h33, perr);
    bus_read(8'h10, oe1, d, oe2, c);
`ifdef AY8_MEM_ROM_PROTECT_EN
    n_tests++; if (perr !== 1'b1) begin $display("FAIL rom_perr got %b want 1", perr); n_fail++; end
    n_tests++; if (d !== 8'hEE) begin $display("FAIL rom_keep got %h want ee", d); n_fail++; end
`else
    n_tests++; if (perr !== 1'b0) begin $display("FAIL rom_perr got %b want 0", perr); n_fail++; end
    n_tests++; if (d !== 8'h33) begin $display("FAIL rom_write got %h want 33", d); n_fail++; end
`endif
    bus_write(8'h80, 8'h5A, perr);
    bus_read(8'h80, oe1, d, oe2, c);
    n_tests++; if (perr !== 1'b0 || d !== 8'h5A) begin $display("FAIL rom_top got %h/%b want 5a/0", d, perr); n_fail++; end
  endtask

  initial begin
    bif.bus_req = 1'b0;
    bif.bus_rw  = MEM_READ;
    bif.bus_in  = 8'h00;
    @(negedge clk);
    test_reset();
    test_load_read();
    test_write_read();
    test_collision();
    test_proto_err();
    test_reset_mid_write();
    test_wrap();
    test_rom_protect();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
